hc595_ctrl: RTL and testbench

Serial driver and sequencer for the two cascaded 74HC595 shift registers that feed the 6-digit seven-segment display.
- Snapshots the parallel sel/seg values (as produced by the static/dynamic segment blocks) at the start of each frame.
- Shifts the 14 bits out on ds/shcp, pulses stcp to latch, then repeats continuously.
- Holds the display blanked via oe until the first complete frame has been latched.

---
 rtl/seg_pkg.sv | 38 +++
 rtl/hc595_tick.sv | 41 ++++
 rtl/hc595_ctrl.sv | 138 +++++++++++++
 tb/tb_hc595_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: frame width,
// 595 sequencer state encodings and active-low hex segment codes.
package seg_pkg;

  localparam int unsigned BIT_NUM = 14;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  // Active-low {dp,g,f,e,d,c,b,a} code for one hex digit.
  function automatic logic [7:0] seg_hex(input logic [3:0] val);
    logic [7:0] code;
    case (val)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      4'hF:    code = 8'h8E;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hc595_tick.sv
// Phase-tick divider for the 595 sequencer: one tick every DIV_MAX+1 cycles,
// restartable from the LOAD cycle so every frame begins on a fresh count.
module hc595_tick #(
  parameter logic [7:0] DIV_MAX = 8'd1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic tick,
  output logic tick_nxt
);

  logic [7:0] div_r;
  logic [7:0] div_nxt_s;

  // Next divider count: clear, wrap at terminal count, or increment.
  always_comb begin
    div_nxt_s = 8'd0;
    if (clr) begin
      div_nxt_s = 8'd0;
    end else if (div_r == DIV_MAX) begin
      div_nxt_s = 8'd0;
    end else begin
      div_nxt_s = div_r + 8'd1;
    end
  end

  // Divider count register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_r <= 8'd0;
    end else begin
      div_r <= div_nxt_s;
    end
  end

  // tick_nxt lets the sequencer register its outputs aligned with its state.
  assign tick     = (div_r == DIV_MAX);
  assign tick_nxt = (div_nxt_s == DIV_MAX);

endmodule

// File: rtl/hc595_ctrl.sv
// Serial driver for two cascaded 74HC595s: snapshots {sel,seg}, shifts 14 bits
// LSB first on ds/shcp, pulses stcp, and unblanks oe after the first frame.
module hc595_ctrl
  import seg_pkg::*;
#(
  parameter logic [7:0] DIV_MAX = 8'd1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] sel,
  input  logic [7:0] seg,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe,
  output logic       frame_done
);

  localparam logic [3:0] LAST_BIT = 4'(BIT_NUM - 1);

  state_e             state_r, state_nxt_s;
  logic [BIT_NUM-1:0] frame_r, frame_nxt_s;
  logic [1:0]         phase_r, phase_nxt_s;
  logic [3:0]         bit_idx_r, bit_idx_nxt_s;
  logic               tick_s, tick_nxt_s, div_clr_s;
  logic               ds_nxt_s, shcp_nxt_s, stcp_nxt_s, frame_done_nxt_s, oe_nxt_s;

  assign div_clr_s = (state_r == ST_LOAD);

  hc595_tick #(.DIV_MAX(DIV_MAX)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (div_clr_s),
    .tick      (tick_s),
    .tick_nxt  (tick_nxt_s)
  );

  // Next-state logic for the LOAD/SHIFT/LATCH sequencer and its counters.
  always_comb begin
    state_nxt_s   = state_r;
    frame_nxt_s   = frame_r;
    phase_nxt_s   = phase_r;
    bit_idx_nxt_s = bit_idx_r;
    case (state_r)
      ST_LOAD: begin
        frame_nxt_s   = {sel, seg};
        phase_nxt_s   = 2'd0;
        bit_idx_nxt_s = 4'd0;
        state_nxt_s   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick_s) begin
          if (phase_r == 2'd3) begin
            phase_nxt_s = 2'd0;
            if (bit_idx_r == LAST_BIT) begin
              bit_idx_nxt_s = 4'd0;
              state_nxt_s   = ST_LATCH;
            end else begin
              bit_idx_nxt_s = bit_idx_r + 4'd1;
            end
          end else begin
            phase_nxt_s = phase_r + 2'd1;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_LATCH: begin
        if (tick_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_LATCH;
        end
      end
      default: begin
        state_nxt_s   = ST_LOAD;
        phase_nxt_s   = 2'd0;
        bit_idx_nxt_s = 4'd0;
      end
    endcase
  end

  // Output decode from the next state, so registered pins line up with state.
  always_comb begin
    ds_nxt_s         = 1'b0;
    shcp_nxt_s       = 1'b0;
    stcp_nxt_s       = 1'b0;
    frame_done_nxt_s = 1'b0;
    if (state_nxt_s == ST_SHIFT) begin
      ds_nxt_s   = frame_nxt_s[bit_idx_nxt_s];
      shcp_nxt_s = phase_nxt_s[1];
    end else if (state_nxt_s == ST_LATCH) begin
      stcp_nxt_s       = 1'b1;
      frame_done_nxt_s = tick_nxt_s;
    end else begin
      ds_nxt_s   = 1'b0;
      shcp_nxt_s = 1'b0;
    end
    if ((state_r == ST_LATCH) && tick_s) begin
      oe_nxt_s = 1'b0;
    end else begin
      oe_nxt_s = oe;
    end
  end

  // Sequencer state and counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_LOAD;
      frame_r   <= '0;
      phase_r   <= 2'd0;
      bit_idx_r <= 4'd0;
    end else begin
      state_r   <= state_nxt_s;
      frame_r   <= frame_nxt_s;
      phase_r   <= phase_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
    end
  end

  // Registered 595 pins; oe stays low once the first frame is latched.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ds         <= 1'b0;
      shcp       <= 1'b0;
      stcp       <= 1'b0;
      oe         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      ds         <= ds_nxt_s;
      shcp       <= shcp_nxt_s;
      stcp       <= stcp_nxt_s;
      oe         <= oe_nxt_s;
      frame_done <= frame_done_nxt_s;
    end
  end

endmodule

// File: tb/tb_hc595_ctrl.sv
// Directed bench for hc595_ctrl: four instances (DIV_MAX 0,1,3,5) share inputs,
// each feeding a two-595 cascade model whose latched word is checked per frame.
`timescale 1ns/1ps
module tb_hc595_ctrl;

  localparam int NDUT = 4;

  logic                  sys_clk   = 1'b0;
  logic                  sys_rst_n = 1'b0;
  logic [5:0]            sel       = 6'h3F;
  logic [7:0]            seg       = 8'hC0;
  logic [NDUT-1:0]       ds_w, shcp_w, stcp_w, oe_w, fd_w;
  logic [NDUT-1:0][13:0] latch_v, exp_v;
  int                    chk_cnt   = 0;
  int                    pass_cnt  = 0;

  // 100 MHz-style bench clock, period 10.
  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam logic [7:0] DV = (g == 0) ? 8'd0 : (g == 1) ? 8'd1 : (g == 2) ? 8'd3 : 8'd5;
    logic [13:0] chain_r   = 14'd0;
    logic [13:0] latch_r   = 14'd0;
    logic [13:0] exp_r     = 14'd0;
    logic        in_load_r = 1'b1;

    hc595_ctrl #(.DIV_MAX(DV)) u_dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .sel        (sel),
      .seg        (seg),
      .ds         (ds_w[g]),
      .shcp       (shcp_w[g]),
      .stcp       (stcp_w[g]),
      .oe         (oe_w[g]),
      .frame_done (fd_w[g])
    );

    // Cascaded shift chain: first 595's Q7' feeds the second; the two
    // unused top outputs of the second device are not modelled.
    always @(posedge shcp_w[g]) chain_r <= {chain_r[12:0], ds_w[g]};
    // Storage register of both 595s.
    always @(posedge stcp_w[g]) latch_r <= chain_r;
    // Expected word: inputs sampled at the edge closing the LOAD cycle.
    always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        in_load_r <= 1'b1;
      end else begin
        if (in_load_r) exp_r <= {sel, seg};
        in_load_r <= fd_w[g];
      end
    end
    // The first bit shifted travels farthest, so frame bit b sits at chain 13-b.
    for (genvar b = 0; b < 14; b++) begin : g_rev
      assign latch_v[g][b] = latch_r[13-b];
    end
    assign exp_v[g] = exp_r;
  end

  task automatic test_reset();
    sys_rst_n = 1'b0;
    sel = 6'h3F;
    seg = 8'hC0;
    repeat (5) @(negedge sys_clk);
    for (int g = 0; g < NDUT; g++) begin
      chk_cnt++;
      if ({ds_w[g], shcp_w[g], stcp_w[g], oe_w[g], fd_w[g]} !== 5'b00010)
        $display("FAIL reset_outputs dut%0d: got %b want 00010", g,
                 {ds_w[g], shcp_w[g], stcp_w[g], oe_w[g], fd_w[g]});
      else pass_cnt++;
    end
  endtask

  task automatic test_first_frame();
    logic [13:0] rx = 14'd0;
    int nb = 0, stcp_n = 0, stcp_k = -1, fd_k = -1;
    logic prev = 1'b0, oe_at_fd = 1'b0, oe_after = 1'b1;
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge sys_clk);
      if (shcp_w[0] && !prev) begin
        if (nb < 14) rx[nb] = ds_w[0];
        nb++;
      end
      prev = shcp_w[0];
      if (stcp_w[0]) begin stcp_n++; stcp_k = k; end
      if (fd_w[0] && fd_k < 0) begin fd_k = k; oe_at_fd = oe_w[0]; end
      if (k == 58) oe_after = oe_w[0];
    end
    chk_cnt++; if (rx !== 14'h3FC0) $display("FAIL first_bits: got %h want 3fc0", rx); else pass_cnt++;
    chk_cnt++; if (nb !== 14) $display("FAIL first_rises: got %0d want 14", nb); else pass_cnt++;
    chk_cnt++; if (stcp_n !== 1) $display("FAIL first_stcp_len: got %0d want 1", stcp_n); else pass_cnt++;
    chk_cnt++; if (stcp_k !== 57) $display("FAIL first_stcp_cycle: got %0d want 57", stcp_k); else pass_cnt++;
    chk_cnt++; if (fd_k !== 57) $display("FAIL first_done_cycle: got %0d want 57", fd_k); else pass_cnt++;
    chk_cnt++; if (oe_at_fd !== 1'b1) $display("FAIL first_oe_blank: got %b want 1", oe_at_fd); else pass_cnt++;
    chk_cnt++; if (oe_after !== 1'b0) $display("FAIL first_oe_on: got %b want 0", oe_after); else pass_cnt++;
  endtask

  task automatic test_period();
    int cyc = 0, rises, stn, ovl = 0;
    logic prev;
    while (!fd_w[0] && cyc < 200) begin @(negedge sys_clk); cyc++; end
    chk_cnt++; if (fd_w[0] !== 1'b1) $display("FAIL period_wait: got %b want 1", fd_w[0]); else pass_cnt++;
    for (int f = 0; f < 3; f++) begin
      cyc = 0; rises = 0; stn = 0; prev = shcp_w[0];
      do begin
        @(negedge sys_clk); cyc++;
        if (shcp_w[0] && !prev) rises++;
        prev = shcp_w[0];
        if (stcp_w[0]) stn++;
        if (shcp_w[0] && stcp_w[0]) ovl++;
      end while (!fd_w[0] && cyc < 200);
      chk_cnt++; if (cyc !== 58) $display("FAIL period_len f%0d: got %0d want 58", f, cyc); else pass_cnt++;
      chk_cnt++; if (rises !== 14) $display("FAIL period_rises f%0d: got %0d want 14", f, rises); else pass_cnt++;
      chk_cnt++; if (stn !== 1) $display("FAIL period_stcp f%0d: got %0d want 1", f, stn); else pass_cnt++;
    end
    chk_cnt++; if (ovl !== 0) $display("FAIL period_overlap: got %0d want 0", ovl); else pass_cnt++;
  endtask

  task automatic test_div3();
    int cyc = 0, rises = 0, hi_run = 0, lo_run = 0, bad_ds = 0;
    int hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
    bit seen = 1'b0, pend = 1'b0;
    logic prev_s, prev_d, ref_d = 1'b0;
    while (!fd_w[2] && cyc < 400) begin @(negedge sys_clk); cyc++; end
    chk_cnt++; if (fd_w[2] !== 1'b1) $display("FAIL div3_wait: got %b want 1", fd_w[2]); else pass_cnt++;
    cyc = 0; prev_s = shcp_w[2]; prev_d = ds_w[2];
    do begin
      @(negedge sys_clk); cyc++;
      if (pend) begin
        if (ds_w[2] !== ref_d) bad_ds++;
        pend = 1'b0;
      end
      if (shcp_w[2] && !prev_s) begin
        rises++;
        if (ds_w[2] !== prev_d) bad_ds++;
        ref_d = ds_w[2]; pend = 1'b1;
        if (seen) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        seen = 1'b1; lo_run = 0;
      end
      if (!shcp_w[2] && prev_s) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0; lo_run = 0;
      end
      if (shcp_w[2]) hi_run++; else lo_run++;
      prev_s = shcp_w[2]; prev_d = ds_w[2];
    end while (!fd_w[2] && cyc < 400);
    chk_cnt++; if (cyc !== 229) $display("FAIL div3_len: got %0d want 229", cyc); else pass_cnt++;
    chk_cnt++; if (rises !== 14) $display("FAIL div3_rises: got %0d want 14", rises); else pass_cnt++;
    chk_cnt++; if (hi_min !== 8 || hi_max !== 8) $display("FAIL div3_high: got %0d..%0d want 8..8", hi_min, hi_max); else pass_cnt++;
    chk_cnt++; if (lo_min !== 8 || lo_max !== 8) $display("FAIL div3_low: got %0d..%0d want 8..8", lo_min, lo_max); else pass_cnt++;
    chk_cnt++; if (bad_ds !== 0) $display("FAIL div3_ds_setup: got %0d want 0", bad_ds); else pass_cnt++;
  endtask

  task automatic test_no_tearing();
    int cyc = 0, nb;
    logic [13:0] rx;
    logic [13:0] want;
    logic prev;
    while (!fd_w[1] && cyc < 300) begin @(negedge sys_clk); cyc++; end
    chk_cnt++; if (fd_w[1] !== 1'b1) $display("FAIL tear_wait: got %b want 1", fd_w[1]); else pass_cnt++;
    for (int f = 0; f < 2; f++) begin
      cyc = 0; nb = 0; rx = 14'd0; prev = shcp_w[1];
      do begin
        @(negedge sys_clk); cyc++;
        if (f == 0 && cyc == 20) seg = 8'hF9;
        if (shcp_w[1] && !prev) begin
          if (nb < 14) rx[nb] = ds_w[1];
          nb++;
        end
        prev = shcp_w[1];
      end while (!fd_w[1] && cyc < 300);
      want = (f == 0) ? 14'h3FC0 : 14'h3FF9;
      chk_cnt++; if (rx !== want) $display("FAIL tear_frame%0d: got %h want %h", f, rx, want); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midframe();
    int cyc = 0, rises = 0, early = 0, fd_k = -1;
    logic prev;
    while (!fd_w[1] && cyc < 300) begin @(negedge sys_clk); cyc++; end
    prev = shcp_w[1]; cyc = 0;
    while (rises < 8 && cyc < 300) begin
      @(negedge sys_clk); cyc++;
      if (shcp_w[1] && !prev) rises++;
      prev = shcp_w[1];
    end
    chk_cnt++; if (shcp_w[1] !== 1'b1) $display("FAIL rst_pre_shcp: got %b want 1", shcp_w[1]); else pass_cnt++;
    chk_cnt++; if (oe_w[1] !== 1'b0) $display("FAIL rst_pre_oe: got %b want 0", oe_w[1]); else pass_cnt++;
    sys_rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({ds_w[1], shcp_w[1], stcp_w[1], oe_w[1], fd_w[1]} !== 5'b00010)
      $display("FAIL rst_async: got %b want 00010", {ds_w[1], shcp_w[1], stcp_w[1], oe_w[1], fd_w[1]});
    else pass_cnt++;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 200 && fd_k < 0; k++) begin
      @(negedge sys_clk);
      if (oe_w[1] !== 1'b1) early++;
      if (fd_w[1]) fd_k = k;
    end
    chk_cnt++; if (fd_k !== 114) $display("FAIL rst_refill_cycle: got %0d want 114", fd_k); else pass_cnt++;
    chk_cnt++; if (early !== 0) $display("FAIL rst_oe_early: got %0d want 0", early); else pass_cnt++;
    chk_cnt++; if (latch_v[1] !== 14'h3FF9) $display("FAIL rst_refill_word: got %h want 3ff9", latch_v[1]); else pass_cnt++;
    @(negedge sys_clk);
    chk_cnt++; if (oe_w[1] !== 1'b0) $display("FAIL rst_oe_on: got %b want 0", oe_w[1]); else pass_cnt++;
  endtask

  task automatic test_cascade();
    int frames = 0, cyc = 0;
    while (frames < 50 && cyc < 30000) begin
      @(negedge sys_clk); cyc++;
      if (cyc % 5 == 0) begin
        sel = 6'($urandom);
        seg = 8'($urandom);
      end
      for (int g = 0; g < NDUT; g++) begin
        if (fd_w[g]) begin
          chk_cnt++;
          if (latch_v[g] !== exp_v[g])
            $display("FAIL cascade dut%0d: got %h want %h", g, latch_v[g], exp_v[g]);
          else pass_cnt++;
          if (g == 3) frames++;
        end
      end
    end
    chk_cnt++; if (frames !== 50) $display("FAIL cascade_frames: got %0d want 50", frames); else pass_cnt++;
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_first_frame();
    test_period();
    test_div3();
    test_no_tearing();
    test_reset_midframe();
    test_cascade();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
